// File: rtl/exec_alu_stage.sv
// Execute stage: single-cycle integer ALU/MOV ops plus multi-cycle signed IMUL
// into RDX:RAX, with a registered writeback slot and architectural RFLAGS.
module exec_alu_stage #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        validIn,
  input  logic        flushIn,
  input  logic        stallIn,
  input  logic [7:0]  opcodeIn,
  input  logic [2:0]  extendedOpcodeIn,
  input  logic [63:0] operandVal1In,
  input  logic [63:0] operandVal2In,
  input  logic [31:0] imm32In,
  input  logic [3:0]  destRegIn,
  input  logic [31:0] currentRipIn,
  output logic        stallOut,
  output logic        wbValidOut,
  output logic [3:0]  wbDestRegOut,
  output logic [63:0] wbResultOut,
  output logic [63:0] wbResultHiOut,
  output logic        wbDualOut,
  output logic        wbIllegalOut,
  output logic [31:0] wbRipOut,
  output logic [63:0] rflagsOut
);

  localparam int unsigned CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic {IDLE, MUL} stateT;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_IMUL, OP_ILL
  } aluOpT;

  stateT               state, stateNext;
  logic [CW-1:0]       counter, counterNext;
  logic [63:0]         mulA, mulB;
  logic [31:0]         mulRip;

  aluOpT               aluOp;
  logic [63:0]         immExt, srcB;
  logic [64:0]         sum65, diff65;
  logic [63:0]         aluResult, flagsNew;
  logic                flagsWrite;
  logic signed [127:0] product;
  logic                mulOvf;
  logic                slotBusy, accept, isMulAccept, mulDone;

  assign immExt = {{32{imm32In[31]}}, imm32In};

  always_comb begin
    aluOp = OP_ILL;
    srcB  = operandVal2In;
    case (opcodeIn)
      8'h01: aluOp = OP_ADD;
      8'h29: aluOp = OP_SUB;
      8'h21: aluOp = OP_AND;
      8'h09: aluOp = OP_OR;
      8'h31: aluOp = OP_XOR;
      8'h81: begin
        srcB = immExt;
        case (extendedOpcodeIn)
          3'd0:    aluOp = OP_ADD;
          3'd1:    aluOp = OP_OR;
          3'd4:    aluOp = OP_AND;
          3'd5:    aluOp = OP_SUB;
          3'd6:    aluOp = OP_XOR;
          default: aluOp = OP_ILL;
        endcase
      end
      8'h89: aluOp = OP_MOV;
      8'hC7: begin
        srcB = immExt;
        if (extendedOpcodeIn == 3'd0) aluOp = OP_MOV;
      end
      8'hF7: if (extendedOpcodeIn == 3'd5) aluOp = OP_IMUL;
      default: aluOp = OP_ILL;
    endcase
  end

  assign sum65  = {1'b0, operandVal1In} + {1'b0, srcB};
  assign diff65 = {1'b0, operandVal1In} - {1'b0, srcB};

  always_comb begin
    aluResult  = '0;
    flagsNew   = rflagsOut;
    flagsWrite = 1'b0;
    case (aluOp)
      OP_ADD: begin
        aluResult    = sum65[63:0];
        flagsWrite   = 1'b1;
        flagsNew[0]  = sum65[64];
        flagsNew[11] = (operandVal1In[63] == srcB[63]) && (sum65[63] != operandVal1In[63]);
      end
      OP_SUB: begin
        aluResult    = diff65[63:0];
        flagsWrite   = 1'b1;
        flagsNew[0]  = diff65[64];
        flagsNew[11] = (operandVal1In[63] != srcB[63]) && (diff65[63] != operandVal1In[63]);
      end
      OP_AND, OP_OR, OP_XOR: begin
        if (aluOp == OP_AND)     aluResult = operandVal1In & srcB;
        else if (aluOp == OP_OR) aluResult = operandVal1In | srcB;
        else                     aluResult = operandVal1In ^ srcB;
        flagsWrite   = 1'b1;
        flagsNew[0]  = 1'b0;
        flagsNew[11] = 1'b0;
      end
      OP_MOV:  aluResult = srcB;
      default: aluResult = '0;
    endcase
    if (flagsWrite) begin
      flagsNew[6] = (aluResult == '0);
      flagsNew[7] = aluResult[63];
    end
    flagsNew[1] = 1'b1;
  end

  assign product = $signed({{64{mulA[63]}}, mulA}) * $signed({{64{mulB[63]}}, mulB});
  assign mulOvf  = (product[127:64] != {64{product[63]}});

  assign slotBusy    = wbValidOut && stallIn;
  assign stallOut    = (state == MUL) || slotBusy;
  assign accept      = validIn && !stallOut && !flushIn;
  assign isMulAccept = accept && (aluOp == OP_IMUL);
  // Completion is taken on the edge where counter leaves 1, so the unit spends
  // MUL_CYCLES-1 cycles in MUL when the output slot is free.
  assign mulDone     = (state == MUL) && (counter <= CW'(1)) && !slotBusy && !flushIn;

  always_comb begin
    stateNext   = state;
    counterNext = counter;
    if (flushIn) begin
      stateNext   = IDLE;
      counterNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (isMulAccept) begin
            stateNext   = MUL;
            counterNext = CW'(MUL_CYCLES - 1);
          end
        end
        MUL: begin
          if (counter > CW'(1)) begin
            counterNext = counter - CW'(1);
          end else if (!slotBusy) begin
            stateNext   = IDLE;
            counterNext = '0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      counter <= '0;
      mulA    <= '0;
      mulB    <= '0;
      mulRip  <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
      if (isMulAccept) begin
        mulA   <= operandVal1In;
        mulB   <= operandVal2In;
        mulRip <= currentRipIn;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbValidOut    <= 1'b0;
      wbDestRegOut  <= '0;
      wbResultOut   <= '0;
      wbResultHiOut <= '0;
      wbDualOut     <= 1'b0;
      wbIllegalOut  <= 1'b0;
      wbRipOut      <= '0;
      rflagsOut     <= 64'h2;
    end else if (flushIn) begin
      wbValidOut    <= 1'b0;
      wbDestRegOut  <= '0;
      wbResultOut   <= '0;
      wbResultHiOut <= '0;
      wbDualOut     <= 1'b0;
      wbIllegalOut  <= 1'b0;
      wbRipOut      <= '0;
    end else if (mulDone) begin
      wbValidOut    <= 1'b1;
      wbDestRegOut  <= '0;
      wbResultOut   <= product[63:0];
      wbResultHiOut <= product[127:64];
      wbDualOut     <= 1'b1;
      wbIllegalOut  <= 1'b0;
      wbRipOut      <= mulRip;
      rflagsOut[0]  <= mulOvf;
      rflagsOut[11] <= mulOvf;
    end else if (accept && !isMulAccept) begin
      wbValidOut    <= 1'b1;
      wbDestRegOut  <= destRegIn;
      wbResultOut   <= aluResult;
      wbResultHiOut <= '0;
      wbDualOut     <= 1'b0;
      wbIllegalOut  <= (aluOp == OP_ILL);
      wbRipOut      <= currentRipIn;
      if (flagsWrite) rflagsOut <= flagsNew;
    end else if (!slotBusy) begin
      wbValidOut    <= 1'b0;
      wbDestRegOut  <= '0;
      wbResultOut   <= '0;
      wbResultHiOut <= '0;
      wbDualOut     <= 1'b0;
      wbIllegalOut  <= 1'b0;
      wbRipOut      <= '0;
    end
  end

endmodule

// File: tb/tb_exec_alu_stage.sv
// Bench for exec_alu_stage: cycle model built from the architectural rules,
// per-cycle comparison, plus directed vectors with literal expectations.
module tb_exec_alu_stage;

  localparam int unsigned MUL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        validIn = 1'b0, flushIn = 1'b0, stallIn = 1'b0;
  logic [7:0]  opcodeIn = '0;
  logic [2:0]  extendedOpcodeIn = '0;
  logic [63:0] operandVal1In = '0, operandVal2In = '0;
  logic [31:0] imm32In = '0;
  logic [3:0]  destRegIn = '0;
  logic [31:0] currentRipIn = '0;
  logic        stallOut, wbValidOut, wbDualOut, wbIllegalOut;
  logic [3:0]  wbDestRegOut;
  logic [63:0] wbResultOut, wbResultHiOut, rflagsOut;
  logic [31:0] wbRipOut;

  exec_alu_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .validIn(validIn), .flushIn(flushIn),
    .stallIn(stallIn), .opcodeIn(opcodeIn), .extendedOpcodeIn(extendedOpcodeIn),
    .operandVal1In(operandVal1In), .operandVal2In(operandVal2In),
    .imm32In(imm32In), .destRegIn(destRegIn), .currentRipIn(currentRipIn),
    .stallOut(stallOut), .wbValidOut(wbValidOut), .wbDestRegOut(wbDestRegOut),
    .wbResultOut(wbResultOut), .wbResultHiOut(wbResultHiOut),
    .wbDualOut(wbDualOut), .wbIllegalOut(wbIllegalOut), .wbRipOut(wbRipOut),
    .rflagsOut(rflagsOut)
  );

  always #5 clk = ~clk;

  int unsigned passCnt = 0, totalCnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  typedef struct packed {
    logic [63:0] res;
    logic        ill;
    logic [63:0] flags;
  } goldT;

  function automatic goldT golden(input logic [7:0] op, input logic [2:0] ext,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [31:0] imm, input logic [63:0] fin);
    goldT g;
    logic [63:0] i64, s, r;
    logic signed [64:0] w;
    logic cf, of;
    int kind;
    i64 = {{32{imm[31]}}, imm};
    s = b;
    kind = 0;
    case (op)
      8'h01: kind = 1;
      8'h29: kind = 2;
      8'h21: kind = 3;
      8'h09: kind = 4;
      8'h31: kind = 5;
      8'h89: kind = 6;
      8'h81: begin
        s = i64;
        case (ext)
          3'd0: kind = 1;
          3'd1: kind = 4;
          3'd4: kind = 3;
          3'd5: kind = 2;
          3'd6: kind = 5;
          default: kind = 0;
        endcase
      end
      8'hC7: begin
        s = i64;
        if (ext == 3'd0) kind = 6;
      end
      default: kind = 0;
    endcase
    g.flags = fin;
    g.ill = 1'b0;
    r = '0; cf = 1'b0; of = 1'b0;
    case (kind)
      1: begin
        r = a + s;
        cf = (r < a);
        w = $signed({a[63], a}) + $signed({s[63], s});
        of = (w[64] != w[63]);
      end
      2: begin
        r = a - s;
        cf = (a < s);
        w = $signed({a[63], a}) - $signed({s[63], s});
        of = (w[64] != w[63]);
      end
      3: r = a & s;
      4: r = a | s;
      5: r = a ^ s;
      6: r = s;
      default: g.ill = 1'b1;
    endcase
    if (kind >= 1 && kind <= 5) begin
      g.flags[0] = cf;
      g.flags[6] = (r == 64'd0);
      g.flags[7] = r[63];
      g.flags[11] = of;
    end
    g.flags[1] = 1'b1;
    g.res = r;
    return g;
  endfunction

  // Reference model state
  logic        eValid, eDual, eIll, mBusy;
  logic [3:0]  eDest;
  logic [63:0] eRes, eHi, eFlags, mA, mB;
  logic [31:0] eRip, mRip;
  int unsigned cyc, mDue;

  task automatic modelClear();
    eValid = 1'b0; eDual = 1'b0; eIll = 1'b0; eDest = '0;
    eRes = '0; eHi = '0; eRip = '0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    logic slotBusy, acc, have;
    logic signed [127:0] p;
    logic ovf;
    goldT g;
    if (!reset_n) begin
      modelClear();
      eFlags = 64'h2;
      mBusy = 1'b0; mA = '0; mB = '0; mRip = '0; cyc = 0; mDue = 0;
    end else begin
      cyc++;
      slotBusy = eValid && stallIn;
      acc = validIn && !(mBusy || slotBusy) && !flushIn;
      if (flushIn) begin
        modelClear();
        mBusy = 1'b0;
      end else begin
        have = 1'b0;
        if (mBusy && cyc >= mDue && !slotBusy) begin
          p = $signed({{64{mA[63]}}, mA}) * $signed({{64{mB[63]}}, mB});
          ovf = (p > $signed(128'h7FFF_FFFF_FFFF_FFFF)) ||
                (p < -$signed(128'h8000_0000_0000_0000));
          mBusy = 1'b0;
          have = 1'b1;
          eDest = 4'd0; eRes = p[63:0]; eHi = p[127:64]; eDual = 1'b1;
          eIll = 1'b0; eRip = mRip;
          eFlags[0] = ovf; eFlags[11] = ovf;
        end else if (acc) begin
          if (opcodeIn == 8'hF7 && extendedOpcodeIn == 3'd5) begin
            mBusy = 1'b1; mDue = cyc + MUL_CYCLES - 1;
            mA = operandVal1In; mB = operandVal2In; mRip = currentRipIn;
          end else begin
            g = golden(opcodeIn, extendedOpcodeIn, operandVal1In, operandVal2In, imm32In, eFlags);
            have = 1'b1;
            eDest = destRegIn; eRes = g.res; eHi = '0; eDual = 1'b0;
            eIll = g.ill; eRip = currentRipIn; eFlags = g.flags;
          end
        end
        if (have) eValid = 1'b1;
        else if (!slotBusy) modelClear();
      end
    end
  end

  logic chkOn = 1'b0;
  always @(posedge clk) begin
    if (chkOn) begin
      #1;
      chk("wbValid", wbValidOut, eValid);
      chk("wbDest", wbDestRegOut, eDest);
      chk("wbResult", wbResultOut, eRes);
      chk("wbResultHi", wbResultHiOut, eHi);
      chk("wbDual", wbDualOut, eDual);
      chk("wbIllegal", wbIllegalOut, eIll);
      chk("wbRip", wbRipOut, eRip);
      chk("rflags", rflagsOut, eFlags);
      chk("stallOut", stallOut, mBusy || (eValid && stallIn));
    end
  end

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(input logic [7:0] op, input logic [2:0] ext, input logic [63:0] a,
                     input logic [63:0] b, input logic [31:0] imm, input logic [3:0] d,
                     input logic [31:0] rp);
    validIn = 1'b1; opcodeIn = op; extendedOpcodeIn = ext; operandVal1In = a;
    operandVal2In = b; imm32In = imm; destRegIn = d; currentRipIn = rp;
  endtask

  typedef struct packed {
    logic [7:0] op; logic [2:0] ext; logic [63:0] a; logic [63:0] b; logic [31:0] imm;
  } vecT;
  vecT vecs [12];

  initial begin
    vecs[0]  = '{8'h01, 3'd0, 64'd5, 64'd7, 32'd0};
    vecs[1]  = '{8'h29, 3'd0, 64'd3, 64'd5, 32'd0};
    vecs[2]  = '{8'h21, 3'd0, 64'hF0F0, 64'h0FF0, 32'd0};
    vecs[3]  = '{8'h09, 3'd0, 64'h8000_0000_0000_0000, 64'h1, 32'd0};
    vecs[4]  = '{8'h31, 3'd0, 64'h1234, 64'h1234, 32'd0};
    vecs[5]  = '{8'h89, 3'd0, 64'd1, 64'h8123_4567_89AB_CDEF, 32'd0};
    vecs[6]  = '{8'hC7, 3'd0, 64'd9, 64'd9, 32'h8000_0000};
    vecs[7]  = '{8'h81, 3'd0, 64'd1, 64'd0, 32'hFFFF_FFFF};
    vecs[8]  = '{8'h81, 3'd1, 64'h100, 64'd0, 32'h0000_0011};
    vecs[9]  = '{8'h81, 3'd4, 64'hFFFF, 64'd0, 32'hFFFF_FF00};
    vecs[10] = '{8'h81, 3'd6, 64'hFF, 64'd0, 32'h0000_00FF};
    vecs[11] = '{8'h29, 3'd0, 64'd5, 64'd5, 32'd0};

    nx(2);
    chk("reset wbValid", wbValidOut, 0);
    chk("reset stallOut", stallOut, 0);
    chk("reset rflags", rflagsOut, 64'h2);
    chk("reset wbResult", wbResultOut, 0);
    reset_n = 1'b1;
    chkOn = 1'b1;
    nx(1);

    drv(8'h01, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 4'd3, 32'h100);
    nx(1);
    validIn = 1'b0;
    chk("add ovf result", wbResultOut, 64'h8000_0000_0000_0000);
    chk("add ovf rflags", rflagsOut, 64'h882);
    chk("add ovf valid", wbValidOut, 1);
    chk("add ovf dest", wbDestRegOut, 3);

    drv(8'h81, 3'd5, 64'd0, 64'hDEAD, 32'd1, 4'd5, 32'h104);
    nx(1);
    validIn = 1'b0;
    chk("sub imm result", wbResultOut, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub imm rflags", rflagsOut, 64'h83);

    for (int i = 0; i < 12; i++) begin
      drv(vecs[i].op, vecs[i].ext, vecs[i].a, vecs[i].b, vecs[i].imm, 4'(i), 32'h200 + 32'(i));
      nx(1);
    end
    validIn = 1'b0;
    chk("sub equal result", wbResultOut, 0);
    chk("sub equal rflags", rflagsOut, 64'h42);

    drv(8'hF7, 3'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 32'd0, 4'd9, 32'h300);
    nx(1);
    validIn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("imul stallOut busy", stallOut, 1);
      chk("imul not yet valid", wbValidOut, 0);
      nx(1);
    end
    chk("imul stallOut done", stallOut, 0);
    chk("imul valid", wbValidOut, 1);
    chk("imul rax", wbResultOut, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("imul rdx", wbResultHiOut, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("imul dual", wbDualOut, 1);
    chk("imul dest", wbDestRegOut, 0);
    chk("imul rflags", rflagsOut, 64'h42);

    drv(8'hF7, 3'd5, 64'h4000_0000_0000_0000, 64'd4, 32'd0, 4'd1, 32'h310);
    nx(1);
    drv(8'h01, 3'd0, 64'd10, 64'd20, 32'd0, 4'd2, 32'h314);
    nx(6);
    validIn = 1'b0;
    nx(1);

    stallIn = 1'b1;
    drv(8'h01, 3'd0, 64'd100, 64'd23, 32'd0, 4'd4, 32'h400);
    nx(1);
    drv(8'h29, 3'd0, 64'd50, 64'd60, 32'd0, 4'd5, 32'h404);
    for (int k = 0; k < 3; k++) begin
      chk("stall stallOut", stallOut, 1);
      chk("stall result held", wbResultOut, 64'd123);
      chk("stall rflags held", rflagsOut, 64'h2);
      nx(1);
    end
    stallIn = 1'b0;
    nx(1);
    validIn = 1'b0;
    chk("after stall result", wbResultOut, 64'hFFFF_FFFF_FFFF_FFF6);
    chk("after stall rflags", rflagsOut, 64'h83);
    nx(1);

    drv(8'hF7, 3'd5, 64'd7, 64'd6, 32'd0, 4'd1, 32'h500);
    nx(1);
    validIn = 1'b0;
    nx(1);
    flushIn = 1'b1;
    nx(1);
    flushIn = 1'b0;
    chk("flush valid", wbValidOut, 0);
    chk("flush stallOut", stallOut, 0);
    chk("flush rflags", rflagsOut, 64'h83);
    nx(4);

    drv(8'h01, 3'd0, 64'd0, 64'd0, 32'd0, 4'd6, 32'h600);
    flushIn = 1'b1;
    nx(1);
    flushIn = 1'b0;
    validIn = 1'b0;
    chk("flush-vs-accept valid", wbValidOut, 0);
    chk("flush-vs-accept rflags", rflagsOut, 64'h83);

    drv(8'h90, 3'd0, 64'd5, 64'd6, 32'd0, 4'd7, 32'h700);
    nx(1);
    validIn = 1'b0;
    chk("illegal flag", wbIllegalOut, 1);
    chk("illegal result", wbResultOut, 0);
    chk("illegal rflags", rflagsOut, 64'h83);
    drv(8'hF7, 3'd3, 64'd5, 64'd6, 32'd0, 4'd8, 32'h704);
    nx(1);
    validIn = 1'b0;
    nx(1);

    drv(8'hF7, 3'd5, 64'd3, 64'd3, 32'd0, 4'd1, 32'h800);
    nx(1);
    validIn = 1'b0;
    nx(1);
    chk("pre-reset stallOut", stallOut, 1);
    reset_n = 1'b0;
    #1;
    chk("mid-imul reset valid", wbValidOut, 0);
    chk("mid-imul reset stallOut", stallOut, 0);
    chk("mid-imul reset rflags", rflagsOut, 64'h2);
    chk("mid-imul reset dual", wbDualOut, 0);
    nx(2);
    reset_n = 1'b1;
    nx(3);
    chkOn = 1'b0;
    nx(1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
